seed_round_ctrl: RTL

//  Round sequencer for the SEED Feistel datapath (left/right round registers, F function, key schedule).
//  - Accepts a block-start request and waits for the key schedule to finish.
//  - Drives Rounds, start_f, clk_en and sync to the round registers; launches F once per round.
//  - Counts 16 rounds and signals completion through a valid/ready handshake.

---
 rtl/seed_pkg.sv | 21 ++
 rtl/seed_round_ctrl_if.sv | 53 +++++
 rtl/seed_clk_en_gen.sv | 31 +++
 rtl/seed_round_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/seed_pkg.sv
// -----------------------------------------------------------------------------
// seed_pkg
// Shared definitions for the SEED round sequencer: round count, round-index
// width, default F timeout and the controller state encoding.
// -----------------------------------------------------------------------------
package seed_pkg;

  localparam int SEED_NUM_ROUNDS = 16;
  localparam int SEED_RND_W      = 4;
  localparam int SEED_F_TIMEOUT  = 63;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_KEY,
    LAUNCH,
    RUN,
    SYNC,
    DONE
  } seed_state_e;

endpackage : seed_pkg

// File: rtl/seed_round_ctrl_if.sv
// -----------------------------------------------------------------------------
// seed_round_ctrl_if
// Handshake / control bundle between the SEED round sequencer and the rest of
// the datapath (block source, key schedule, F function, round registers and
// ciphertext consumer).
//   master : the sequencer (drives blk_ready, f_go, start_f, clk_en, sync,
//            Rounds, sk_idx, out_valid, err)
//   slave  : the surrounding datapath (drives blk_valid, key_ready, f_done,
//            out_ready and, when SEED_DECRYPT_EN is defined, dec)
// Optional feature macro: SEED_DECRYPT_EN adds the dec signal.
// -----------------------------------------------------------------------------
interface seed_round_ctrl_if
  import seed_pkg::*;
#(
  parameter int RND_W = SEED_RND_W
);

  logic             blk_valid;
  logic             blk_ready;
  logic             key_ready;
  logic             f_done;
  logic             f_go;
  logic             start_f;
  logic             clk_en;
  logic             sync;
  logic [RND_W-1:0] Rounds;
  logic [RND_W-1:0] sk_idx;
  logic             out_valid;
  logic             out_ready;
  logic             err;
`ifdef SEED_DECRYPT_EN
  logic             dec;
`endif

  modport master (
    input  blk_valid, key_ready, f_done, out_ready,
`ifdef SEED_DECRYPT_EN
    input  dec,
`endif
    output blk_ready, f_go, start_f, clk_en, sync, Rounds, sk_idx,
           out_valid, err
  );

  modport slave (
    output blk_valid, key_ready, f_done, out_ready,
`ifdef SEED_DECRYPT_EN
    output dec,
`endif
    input  blk_ready, f_go, start_f, clk_en, sync, Rounds, sk_idx,
           out_valid, err
  );

endinterface : seed_round_ctrl_if

// File: rtl/seed_clk_en_gen.sv
// -----------------------------------------------------------------------------
// seed_clk_en_gen
// Free-running divide-by-two enable for the round registers. Low on the first
// cycle after reset, then 1,0,1,... regardless of controller state.
//   clk      in  clock
//   reset_n  in  synchronous active-low reset
//   clk_en_o out enable pulse to the round registers
//   phase_o  out same phase as clk_en_o; the sequencer's view of the capture
//                cycle (kept separate so the FSM does not depend on the bus)
// -----------------------------------------------------------------------------
module seed_clk_en_gen (
  input  logic clk,
  input  logic reset_n,
  output logic clk_en_o,
  output logic phase_o
);

  logic en_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      en_q <= 1'b0;
    end else begin
      en_q <= ~en_q;
    end
  end

  assign clk_en_o = en_q;
  assign phase_o  = en_q;

endmodule : seed_clk_en_gen

// File: rtl/seed_round_ctrl.sv
// -----------------------------------------------------------------------------
// seed_round_ctrl
// Round sequencer for the SEED Feistel datapath. Accepts a block, waits for
// the key schedule, launches F once per round, aligns each round capture to a
// clk_en cycle, counts NUM_ROUNDS rounds and hands the result over through a
// valid/ready handshake. A missing f_done after F_TIMEOUT RUN cycles sets the
// sticky err flag and returns to IDLE (F_TIMEOUT = 0 disables the check).
// Ports:
//   clk      in  clock
//   reset_n  in  synchronous active-low reset
//   bus      seed_round_ctrl_if.master (see the interface file for signals)
// Optional feature macro: SEED_DECRYPT_EN -- samples bus.dec on block accept
// and reverses the subkey order (sk_idx = NUM_ROUNDS-1-Rounds) when set.
// -----------------------------------------------------------------------------
module seed_round_ctrl
  import seed_pkg::*;
#(
  parameter int NUM_ROUNDS = SEED_NUM_ROUNDS,
  parameter int RND_W      = SEED_RND_W,
  parameter int F_TIMEOUT  = SEED_F_TIMEOUT
) (
  input  logic               clk,
  input  logic               reset_n,
  seed_round_ctrl_if.master  bus
);

  localparam int               TO_W     = (F_TIMEOUT > 1) ? $clog2(F_TIMEOUT) : 1;
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'((F_TIMEOUT > 0) ? F_TIMEOUT - 1 : 0);
  localparam logic [RND_W-1:0] RND_LAST = RND_W'(NUM_ROUNDS - 1);

  logic phase;

  seed_clk_en_gen u_clk_en_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .clk_en_o (bus.clk_en),
    .phase_o  (phase)
  );

  seed_state_e      state_q,  state_d;
  logic [RND_W-1:0] rounds_q, rounds_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic             err_q,    err_d;
  logic             blk_ready_q, f_go_q, start_f_q, sync_q, out_valid_q;
`ifdef SEED_DECRYPT_EN
  logic             dec_q,    dec_d;
`endif

  // Next-state logic. Outputs are decoded from state_d and registered below,
  // so every output is a flop that changes together with the state.
  always_comb begin
    // NOTE: every variable gets a default before the case; a path that left
    // one unassigned would infer a latch.
    state_d  = state_q;
    rounds_d = rounds_q;
    to_cnt_d = to_cnt_q;
    err_d    = err_q;
`ifdef SEED_DECRYPT_EN
    dec_d    = dec_q;
`endif
    unique case (state_q)
      IDLE: begin
        rounds_d = '0;
        to_cnt_d = '0;
        if (bus.blk_valid) begin
          state_d = WAIT_KEY;
`ifdef SEED_DECRYPT_EN
          dec_d   = bus.dec;
`endif
        end
      end
      WAIT_KEY: begin
        if (bus.key_ready) state_d = LAUNCH;
      end
      LAUNCH: begin
        state_d  = RUN;
        to_cnt_d = '0;
      end
      RUN: begin
        // f_done takes priority over a timeout expiring on the same cycle.
        if (bus.f_done) begin
          state_d = SYNC;
        end else if ((F_TIMEOUT != 0) && (to_cnt_q == TO_LAST)) begin
          err_d    = 1'b1;
          state_d  = IDLE;
          rounds_d = '0;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      SYNC: begin
        // Leave only on the capture cycle so the round regs see sync&clk_en.
        if (phase) begin
          if (rounds_q == RND_LAST) begin
            state_d = DONE;
          end else begin
            rounds_d = rounds_q + 1'b1;
            state_d  = LAUNCH;
          end
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d  = IDLE;
          rounds_d = '0;
        end
      end
      default: begin
        state_d  = IDLE;
        rounds_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state elements use non-blocking assignments so all flops update
    // from the same pre-edge values.
    if (!reset_n) begin
      state_q     <= IDLE;
      rounds_q    <= '0;
      to_cnt_q    <= '0;
      err_q       <= 1'b0;
      blk_ready_q <= 1'b1;
      f_go_q      <= 1'b0;
      start_f_q   <= 1'b0;
      sync_q      <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef SEED_DECRYPT_EN
      dec_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rounds_q    <= rounds_d;
      to_cnt_q    <= to_cnt_d;
      err_q       <= err_d;
      blk_ready_q <= (state_d == IDLE);
      f_go_q      <= (state_d == LAUNCH);
      start_f_q   <= (state_d == LAUNCH) || (state_d == RUN) ||
                     (state_d == SYNC)   || (state_d == DONE);
      sync_q      <= (state_d == SYNC);
      out_valid_q <= (state_d == DONE);
`ifdef SEED_DECRYPT_EN
      dec_q       <= dec_d;
`endif
    end
  end

  assign bus.blk_ready = blk_ready_q;
  assign bus.f_go      = f_go_q;
  assign bus.start_f   = start_f_q;
  assign bus.sync      = sync_q;
  assign bus.out_valid = out_valid_q;
  assign bus.err       = err_q;
  assign bus.Rounds    = rounds_q;

`ifdef SEED_DECRYPT_EN
  assign bus.sk_idx = dec_q ? (RND_LAST - rounds_q) : rounds_q;
`else
  assign bus.sk_idx = rounds_q;
`endif

endmodule : seed_round_ctrl
